// File: rtl/id_seg_pkg.sv
// Shared constants for the instruction-decode segment: opcodes, IR field positions, default widths.
package id_seg_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_ANDI  = 6'b001100;
    localparam opcode_t OP_ORI   = 6'b001101;
    localparam opcode_t OP_XORI  = 6'b001110;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_J     = 6'b000010;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Logical immediates are zero-extended; everything else is sign-extended.
    function automatic logic is_zero_ext(input opcode_t op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/id_seg_reg_file.sv
// 2-read/1-write register file with r0 hardwired to zero; ID_WB_BYPASS_EN adds same-cycle write-through.
module reg_file
    import id_seg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              w_wr_en;

    assign w_wr_en = i_we && (i_waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Address 0 never bypasses because w_wr_en already excludes it.
    always_comb begin
        o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
        o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];
`ifdef ID_WB_BYPASS_EN
        if (w_wr_en && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end
        if (w_wr_en && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end
`endif
    end

endmodule

// File: rtl/id_seg.sv
// Instruction-decode segment: field decode, immediate extension and the ID/EX latch.
// Optional macro ID_WB_BYPASS_EN enables writeback-to-operand bypass in the register file.
module id_seg
    import id_seg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       IR_i,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] WB_Data,
    input  logic              WB_Write,
    input  logic [ADDR_W-1:0] WB_Addr,
    output logic [DATA_W-1:0] A_o,
    output logic [DATA_W-1:0] B_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [31:0]       IR_o
);

    logic [ADDR_W-1:0] w_rs;
    logic [ADDR_W-1:0] w_rt;
    opcode_t           w_op;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_imm_ext;

    assign w_rs  = IR_i[RS_MSB:RS_LSB];
    assign w_rt  = IR_i[RT_MSB:RT_LSB];
    assign w_op  = IR_i[OP_MSB:OP_LSB];
    assign w_imm = IR_i[IMM_MSB:IMM_LSB];

    assign w_imm_ext = is_zero_ext(w_op) ? {{(DATA_W-16){1'b0}}, w_imm}
                                         : {{(DATA_W-16){w_imm[15]}}, w_imm};

    reg_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .i_we      (WB_Write),
        .i_waddr   (WB_Addr),
        .i_wdata   (WB_Data),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    // A flush loads IR=0, which is the canonical NOP sll r0,r0,0.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            A_o   <= '0;
            B_o   <= '0;
            Imm_o <= '0;
            IR_o  <= '0;
        end else if (!stall) begin
            A_o   <= w_rd_a;
            B_o   <= w_rd_b;
            Imm_o <= w_imm_ext;
            IR_o  <= IR_i;
        end
    end

endmodule

// File: tb/tb_id_seg.sv
// Self-checking bench for id_seg: directed scenarios plus randomized traffic against a behavioural model.
module tb_id_seg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IR_i;
    logic        stall;
    logic        flush;
    logic [31:0] WB_Data;
    logic        WB_Write;
    logic [4:0]  WB_Addr;
    logic [31:0] A_o;
    logic [31:0] B_o;
    logic [31:0] Imm_o;
    logic [31:0] IR_o;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: architectural register contents and expected ID/EX values.
    logic [31:0] mRegs [32];
    logic [31:0] eA, eB, eImm, eIR;

    id_seg dut (
        .clk      (clk),
        .rst      (rst),
        .IR_i     (IR_i),
        .stall    (stall),
        .flush    (flush),
        .WB_Data  (WB_Data),
        .WB_Write (WB_Write),
        .WB_Addr  (WB_Addr),
        .A_o      (A_o),
        .B_o      (B_o),
        .Imm_o    (Imm_o),
        .IR_o     (IR_o)
    );

    always #5 clk = ~clk;

    function automatic void modelEdge();
        logic [31:0] va, vb;
        logic [5:0]  op;
        int          rs, rt;
        if (rst) begin
            for (int i = 0; i < 32; i++) mRegs[i] = '0;
            eA = '0; eB = '0; eImm = '0; eIR = '0;
            return;
        end
        rs = int'(IR_i[25:21]);
        rt = int'(IR_i[20:16]);
        op = IR_i[31:26];
        va = mRegs[rs];
        vb = mRegs[rt];
`ifdef ID_WB_BYPASS_EN
        if (WB_Write && WB_Addr != 0 && int'(WB_Addr) == rs) va = WB_Data;
        if (WB_Write && WB_Addr != 0 && int'(WB_Addr) == rt) vb = WB_Data;
`endif
        if (WB_Write && WB_Addr != 0) mRegs[WB_Addr] = WB_Data;
        if (flush) begin
            eA = '0; eB = '0; eImm = '0; eIR = '0;
        end else if (!stall) begin
            eA   = va;
            eB   = vb;
            eImm = (op == 6'd12 || op == 6'd13 || op == 6'd14)
                   ? {16'h0000, IR_i[15:0]} : 32'($signed(IR_i[15:0]));
            eIR  = IR_i;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input logic we,
                                 input logic [4:0] wa, input logic [31:0] wd);
        IR_i = ir; WB_Write = we; WB_Addr = wa; WB_Data = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 0; flush = 0;
        applyStimulus(32'h00221820, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        checkCount++;
        if ({A_o, B_o, Imm_o, IR_o} !== 128'h0)
            $display("[TB] FAIL reset_outputs: got %h %h %h %h expected all 0", A_o, B_o, Imm_o, IR_o);
        else passCount++;
        rst = 1'b0;
        tick();
        checkCount++;
        if (A_o !== 32'h0 || B_o !== 32'h0)
            $display("[TB] FAIL first_load_operands: got A=%h B=%h expected 0 0", A_o, B_o);
        else passCount++;
        checkCount++;
        if (IR_o !== 32'h00221820 || Imm_o !== 32'h00001820)
            $display("[TB] FAIL first_load_ir_imm: got IR=%h Imm=%h expected 00221820 00001820", IR_o, Imm_o);
        else passCount++;
    endtask

    task automatic test_writeback();
        applyStimulus(32'h00221820, 1'b1, 5'd1, 32'd123);
        tick();
        applyStimulus(32'h00221820, 1'b1, 5'd2, 32'd456);
        tick();
        applyStimulus(32'h00221820, 1'b0, 5'd0, 32'h0);
        tick();
        checkCount++;
        if (A_o !== 32'd123) $display("[TB] FAIL wb_read_r1: got %0d expected 123", A_o);
        else passCount++;
        checkCount++;
        if (B_o !== 32'd456) $display("[TB] FAIL wb_read_r2: got %0d expected 456", B_o);
        else passCount++;
    endtask

    task automatic test_r0();
        applyStimulus(32'h00221820, 1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        applyStimulus(32'h00001820, 1'b0, 5'd0, 32'h0);
        tick();
        checkCount++;
        if (A_o !== 32'h0 || B_o !== 32'h0)
            $display("[TB] FAIL r0_hardwired: got A=%h B=%h expected 0 0", A_o, B_o);
        else passCount++;
    endtask

    task automatic test_imm_ext();
        applyStimulus(32'h2001FFFF, 1'b0, 5'd0, 32'h0);
        tick();
        checkCount++;
        if (Imm_o !== 32'hFFFFFFFF) $display("[TB] FAIL imm_sign_addi: got %h expected ffffffff", Imm_o);
        else passCount++;
        applyStimulus(32'h3001FFFF, 1'b0, 5'd0, 32'h0);
        tick();
        checkCount++;
        if (Imm_o !== 32'h0000FFFF) $display("[TB] FAIL imm_zero_andi: got %h expected 0000ffff", Imm_o);
        else passCount++;
        applyStimulus(32'h39E17FFF, 1'b0, 5'd0, 32'h0);
        tick();
        checkCount++;
        if (Imm_o !== 32'h00007FFF) $display("[TB] FAIL imm_zero_xori: got %h expected 00007fff", Imm_o);
        else passCount++;
    endtask

    task automatic test_bypass();
        logic [31:0] expA;
`ifdef ID_WB_BYPASS_EN
        expA = 32'd789;
`else
        expA = 32'd123;
`endif
        applyStimulus(32'h00221820, 1'b1, 5'd1, 32'd789);
        tick();
        checkCount++;
        if (A_o !== expA) $display("[TB] FAIL same_cycle_write: got %0d expected %0d", A_o, expA);
        else passCount++;
        applyStimulus(32'h00221820, 1'b0, 5'd0, 32'h0);
        tick();
        checkCount++;
        if (A_o !== 32'd789) $display("[TB] FAIL write_visible_next: got %0d expected 789", A_o);
        else passCount++;
    endtask

    task automatic test_stall_flush();
        stall = 1'b1;
        applyStimulus(32'h00843020, 1'b1, 5'd4, 32'h0000ABCD);
        tick();
        applyStimulus(32'h2001FFFF, 1'b0, 5'd0, 32'h0);
        tick();
        checkCount++;
        if (A_o !== 32'd789 || B_o !== 32'd456 || IR_o !== 32'h00221820 || Imm_o !== 32'h00001820)
            $display("[TB] FAIL stall_hold: got %h %h %h %h expected 315 1c8 1820 00221820", A_o, B_o, Imm_o, IR_o);
        else passCount++;
        stall = 1'b0;
        applyStimulus(32'h00843020, 1'b0, 5'd0, 32'h0);
        tick();
        checkCount++;
        if (A_o !== 32'h0000ABCD || B_o !== 32'h0000ABCD || IR_o !== 32'h00843020)
            $display("[TB] FAIL write_during_stall: got A=%h B=%h IR=%h expected abcd abcd 00843020", A_o, B_o, IR_o);
        else passCount++;
        stall = 1'b1; flush = 1'b1;
        tick();
        checkCount++;
        if ({A_o, B_o, Imm_o, IR_o} !== 128'h0)
            $display("[TB] FAIL flush_beats_stall: got %h %h %h %h expected all 0", A_o, B_o, Imm_o, IR_o);
        else passCount++;
        stall = 1'b0; flush = 1'b0;
        applyStimulus(32'h00A00000, 1'b1, 5'd5, 32'h12345678);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(32'h00A00000, 1'b0, 5'd0, 32'h0);
        tick();
        checkCount++;
        if (A_o !== 32'h0) $display("[TB] FAIL reset_beats_write: got %h expected 0", A_o);
        else passCount++;
    endtask

    task automatic test_random();
        logic [5:0] ops [9];
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h02};
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 5) == 0);
            IR_i  = $urandom;
            IR_i[31:26] = ops[$urandom_range(0, 8)];
            WB_Write = $urandom_range(0, 1);
            WB_Addr  = ($urandom_range(0, 3) == 0) ? IR_i[25:21] : 5'($urandom_range(0, 31));
            WB_Data  = $urandom;
            tick();
            checkCount++;
            if ({A_o, B_o, Imm_o, IR_o} !== {eA, eB, eImm, eIR})
                $display("[TB] FAIL random_%0d: got %h %h %h %h expected %h %h %h %h",
                         n, A_o, B_o, Imm_o, IR_o, eA, eB, eImm, eIR);
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_r0();
        test_imm_ext();
        test_bypass();
        test_stall_flush();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/id_seg.md
Name: id_seg

Overview:
- Instruction-decode segment of the 5-stage R/I/J pipeline. It owns the 32-entry register file and is the consumer of the writeback interface (WB_Data / WB_Write / WB_Addr) driven by the writeback segment.
- Decodes rs/rt/imm fields from IR_i and latches operands A, B, the extended immediate and the IR into the ID/EX boundary registers.
- Output latency is 1 clock.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register address width; register count is 2**ADDR_W

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- IR_i  in  32  instruction from IF/ID
- stall  in  1  hold ID/EX outputs; register-file writes still occur
- flush  in  1  load a bubble into ID/EX
- WB_Data  in  DATA_W  writeback data
- WB_Write  in  1  writeback enable
- WB_Addr  in  ADDR_W  writeback destination register
- A_o  out  DATA_W  rs operand, registered
- B_o  out  DATA_W  rt operand, registered
- Imm_o  out  DATA_W  extended IR[15:0], registered
- IR_o  out  32  IR passed to EX, registered

Behaviour:
- Reset (posedge clk with rst=1):
  - r1..r31 <= 0.
  - A_o, B_o, Imm_o, IR_o <= 0.
  - A concurrent WB_Write is ignored, because reset wins.
- r0 is hardwired to 0. Writes with WB_Addr=0 are discarded. Reads of r0 return 0.
- Register write (posedge, rst=0): if WB_Write=1 and WB_Addr!=0, then regs[WB_Addr] <= WB_Data. Writes happen regardless of stall or flush.
- Field decode:
  - rs = IR_i[25:21]
  - rt = IR_i[20:16]
  - op = IR_i[31:26]
- Read value rd(x):
  - If the bypass condition holds (see Optional Feature), return WB_Data.
  - Otherwise return regs[x].
  - Reads are combinational inside the block and are seen only through the ID/EX latch.
- Immediate extension:
  - op in {001100 andi, 001101 ori, 001110 xori}: zero-extend IR_i[15:0].
  - All other opcodes: sign-extend IR_i[15:0].
  - J-type instructions pass IR_o intact; EX extracts target[25:0] itself.
- ID/EX latch, priority rst > flush > stall > load:
  - flush: A_o, B_o, Imm_o, IR_o <= 0. IR=0 is the NOP `sll r0,r0,0`.
  - stall: all four outputs hold.
  - load: A_o <= rd(rs), B_o <= rd(rt), Imm_o <= ext(imm), IR_o <= IR_i.
- Simultaneous flush and stall: flush wins.
- Reset mid-stream: outputs clear in the same cycle. The first valid load occurs on the first posedge after rst drops.
- No arithmetic beyond extension. All widths are exact, with no truncation except the imm field select.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: same-cycle write-through. If WB_Write=1, WB_Addr!=0 and WB_Addr==rs (or rt), the corresponding operand latches WB_Data on the same edge the register is written.
- Undefined: operands latch the pre-write regs[] value. The hazard is then covered by the pipeline stalling one extra cycle, which is the responsibility of the hazard unit outside this block.
- r0 is never bypassed in either case.

Decomposition:
- Shared package:
  - opcode constants (OP_RTYPE 000000, OP_ADDI 001000, OP_ANDI 001100, OP_ORI 001101, OP_XORI 001110, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_J 000010)
  - IR field bit positions
  - DATA_W / ADDR_W defaults
- One sub-module, reg_file:
  - 2 read ports, 1 write port, r0 hardwiring, synchronous reset clear, and the bypass mux under ID_WB_BYPASS_EN.
  - id_seg holds the decode, extension and ID/EX latch.

Test Plan:
1. Reset, then no writes; IR_i=0x00221820 (add r3,r1,r2) -> next edge A_o=0, B_o=0, IR_o=0x00221820, Imm_o=0x00001820.
2. WB_Write=1, WB_Addr=1, WB_Data=123, then next cycle WB_Addr=2, WB_Data=456; afterwards IR_i=0x00221820 -> A_o=123, B_o=456.
3. WB_Write=1, WB_Addr=0, WB_Data=0xDEADBEEF; then IR_i with rs=0 -> A_o=0.
4. IR_i=0x2001FFFF (addi) -> Imm_o=0xFFFFFFFF; IR_i=0x3001FFFF (andi) -> Imm_o=0x0000FFFF.
5. Same-cycle write r1=789 while IR_i reads rs=1 -> A_o=789 with ID_WB_BYPASS_EN defined; A_o=old r1 (123) without it. One cycle later A_o=789 in both builds.
6. Stall=1 for 2 cycles with IR_i changing -> outputs hold, and a write during the stall is visible after release. Then flush=1 together with stall=1 -> all outputs 0. Then rst=1 together with WB_Write=1 to r5 -> r5 reads 0.
